conv_window_5x5: RTL and testbench
==================================

# conv_window_5x5

Sliding-window former that sits directly downstream of the 5-row line buffer in the LeNet datapath. Each valid cycle it takes one 5-pixel vertical column and shifts it into a 5×5 register window. It tracks row and column position within the square feature map and asserts `win_valid` only when the window holds a legal kernel position. For the pooling modes it gates output to stride-2 2×2 positions.

## Interface
- `DATA_WIDTH`, 8, pixel width
- `MAX_WIDTH`, 32, largest feature-map side; counter width is `$clog2(MAX_WIDTH)`
- `FEATURE_MAP1_SIZE`..`FEATURE_MAP5_SIZE`, 32/28/14/10/5, map sides per mode
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  3  000..100 conv modes on sides 32/28/14/10/5; 101 pool on 28; 110 pool on 10; 111 treated as 000
- `pix_valid`  in  1  the column inputs carry a new pixel column this cycle
- `col_in_0`..`col_in_4`  in  DATA_WIDTH each  vertical column; `_0` is the oldest (top) row, `_4` the newest
- `win_out`  out  25*DATA_WIDTH  window; element (r,c) at bits `[(r*5+c)*DATA_WIDTH +: DATA_WIDTH]`; r=0 is top, c=0 is oldest/left, c=4 is newest
- `win_valid`  out  1  `win_out` holds a legal window
- `win_row`, `win_col`  out  `$clog2(MAX_WIDTH)` each  input coordinates of the window's bottom-right pixel
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- The FSM has two states: IDLE and RUN. The reset state is IDLE.
- IDLE:
  - `mode` is latched into `mode_q` and W is decoded from it, only on the first `pix_valid`.
  - That pixel is taken as (row 0, col 0), and the FSM moves to RUN.
  - A `mode` change is ignored while in RUN.
- On every `pix_valid` (in IDLE or RUN):
  - Each window row r shifts left: c0←c1, …, c3←c4, c4←`col_in_r`.
  - col increments. When col = W−1, col wraps to 0 and row increments.
  - At (row W−1, col W−1) the FSM returns to IDLE and row/col clear to 0.
- When `pix_valid`=0, all state holds. Gaps of any length are legal.
- Conv-mode valid rule: valid when row ≥ 4 and col ≥ 4 for the pixel just shifted in. Columns 0–3 of a new row contain stale data from the previous row and are never flagged.
- Pool modes (2×2 uses window elements (3,3),(3,4),(4,3),(4,4)):
  - Valid rule: row ≥ 1 and col ≥ 1, with the stride gating defined under Configuration.
- `win_row`/`win_col` are the row/col of the pixel that completed the window.
- Mode decode: 000→32, 001→28, 010→14, 011→10, 100→5, 101→28, 110→10, 111→32.
- W=5 (mode 100) produces exactly one window per frame.

## Timing
- Latency: the column presented with `pix_valid` at edge N appears at `win_out` c4 after edge N. `win_valid`, `win_row` and `win_col` update at the same edge.
- `win_valid` is high for exactly one cycle per legal window. It is low in any cycle following `pix_valid`=0.
- `frame_done` rises at the same edge as the `win_valid` of the frame's last pixel and lasts one cycle. It pulses even when that pixel yields no window, which cannot occur in the defined modes.
- A new frame may start on the cycle immediately after the last pixel, with no bubble required. `mode` is re-latched on that first pixel.
- Reset values: `win_out`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `frame_done`=0, state IDLE, `mode_q`=000.
- Reset mid-frame aborts the frame immediately: no `frame_done` and no partial window. The next `pix_valid` is treated as (0,0).

## Configuration
- Macro: `CONV_WINDOW_POOL_STRIDE2_EN`.
- Defined: in pool modes, valid additionally requires row and col to be odd (stride 2). Mode 101 yields 14×14=196 windows; mode 110 yields 5×5=25 windows.
- Undefined: pool modes use stride 1 (every row ≥ 1, col ≥ 1). Mode 101 yields 27×27=729 windows; mode 110 yields 81 windows.
- Conv modes are unaffected either way.

## Test plan
- Mode 100, 25 consecutive `pix_valid` columns with `col_in_r` = 10·r + col: exactly one `win_valid`, after the 25th column, with `win_row`=4, `win_col`=4. Element (r,c) = 10·r + c, and `frame_done` is high in the same cycle.
- Mode 000 full frame of 1024 columns, `pix_valid` held high: 784 `win_valid` pulses. The first is at (4,4); none occur at col < 4; the last is at (31,31) together with `frame_done`.
- Mode 001 frame with `pix_valid` toggling 1/0: 576 windows, identical contents to a gap-free run. `win_valid` is never high in a cycle after `pix_valid`=0.
- Mode 101 with `CONV_WINDOW_POOL_STRIDE2_EN` defined: 196 windows, all at odd (row,col), the first at (1,1). Rebuilt without the macro: 729 windows.
- `mode` changed from 000 to 011 at column 100 of a frame: the frame still completes as W=32 (784 windows). The next frame runs at W=10 (36 windows).
- `rst` asserted at column 500 of a mode 000 frame: outputs go to 0 asynchronously and no `frame_done` is produced. A fresh frame then yields 784 windows.

Source files
------------

// File: rtl/conv_window_5x5.sv
// ---------------------------------------------------------------------------
// conv_window_5x5 : 5x5 sliding window former with row/col tracking, rev 1.0
// Optional macro CONV_WINDOW_POOL_STRIDE2_EN: stride-2 gating in pool modes.
// ---------------------------------------------------------------------------
`default_nettype none

module conv_window_5x5 #(
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_WIDTH         = 32,
  parameter int FEATURE_MAP1_SIZE = 32,
  parameter int FEATURE_MAP2_SIZE = 28,
  parameter int FEATURE_MAP3_SIZE = 14,
  parameter int FEATURE_MAP4_SIZE = 10,
  parameter int FEATURE_MAP5_SIZE = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    mode,
  input  logic                          pix_valid,
  input  logic [DATA_WIDTH-1:0]         col_in_0,
  input  logic [DATA_WIDTH-1:0]         col_in_1,
  input  logic [DATA_WIDTH-1:0]         col_in_2,
  input  logic [DATA_WIDTH-1:0]         col_in_3,
  input  logic [DATA_WIDTH-1:0]         col_in_4,
  output logic [25*DATA_WIDTH-1:0]      win_out,
  output logic                          win_valid,
  output logic [$clog2(MAX_WIDTH)-1:0]  win_row,
  output logic [$clog2(MAX_WIDTH)-1:0]  win_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(MAX_WIDTH);

  localparam logic [CW-1:0] LAST1 = CW'(FEATURE_MAP1_SIZE - 1);
  localparam logic [CW-1:0] LAST2 = CW'(FEATURE_MAP2_SIZE - 1);
  localparam logic [CW-1:0] LAST3 = CW'(FEATURE_MAP3_SIZE - 1);
  localparam logic [CW-1:0] LAST4 = CW'(FEATURE_MAP4_SIZE - 1);
  localparam logic [CW-1:0] LAST5 = CW'(FEATURE_MAP5_SIZE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nx;
  logic [2:0]            mode_q;
  logic [2:0]            mode_eff;
  logic [CW-1:0]         row, col;
  logic [CW-1:0]         last_idx;
  logic                  at_col_end, at_frame_end;
  logic                  is_pool, legal;
  logic [DATA_WIDTH-1:0] col_in [5];
  logic [DATA_WIDTH-1:0] win [5][5];

  assign col_in[0] = col_in_0;
  assign col_in[1] = col_in_1;
  assign col_in[2] = col_in_2;
  assign col_in[3] = col_in_3;
  assign col_in[4] = col_in_4;

  // The incoming mode only matters on the first pixel of a frame (IDLE).
  assign mode_eff = (state == IDLE) ? mode : mode_q;

  always_comb begin
    last_idx = LAST1;
    case (mode_eff)
      3'b000:  last_idx = LAST1;
      3'b001:  last_idx = LAST2;
      3'b010:  last_idx = LAST3;
      3'b011:  last_idx = LAST4;
      3'b100:  last_idx = LAST5;
      3'b101:  last_idx = LAST2;
      3'b110:  last_idx = LAST4;
      default: last_idx = LAST1;
    endcase
  end

  assign at_col_end   = (col == last_idx);
  assign at_frame_end = at_col_end && (row == last_idx);
  assign is_pool      = (mode_eff == 3'b101) || (mode_eff == 3'b110);

  always_comb begin
    legal = 1'b0;
    if (is_pool) begin
`ifdef CONV_WINDOW_POOL_STRIDE2_EN
      legal = (row >= CW'(1)) && (col >= CW'(1)) && row[0] && col[0];
`else
      legal = (row >= CW'(1)) && (col >= CW'(1));
`endif
    end else begin
      legal = (row >= CW'(4)) && (col >= CW'(4));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pix_valid) state_nx = at_frame_end ? IDLE : RUN;
      RUN:     if (pix_valid && at_frame_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 3'b000;
      row    <= '0;
      col    <= '0;
    end else if (pix_valid) begin
      if (state == IDLE) mode_q <= mode;
      if (at_col_end) begin
        col <= '0;
        row <= at_frame_end ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
        win[r][4] <= col_in[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= pix_valid && legal;
      frame_done <= pix_valid && at_frame_end;
      if (pix_valid) begin
        win_row <= row;
        win_col <= col;
      end
    end
  end

  for (genvar gr = 0; gr < 5; gr++) begin : g_row
    for (genvar gc = 0; gc < 5; gc++) begin : g_col
      assign win_out[(gr*5+gc)*DATA_WIDTH +: DATA_WIDTH] = win[gr][gc];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_5x5.sv
// ---------------------------------------------------------------------------
// tb_conv_window_5x5 : randomized frame-level bench with a pixel-index model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_5x5;

  localparam int DW = 8;
  localparam int CW = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         mode;
  logic               pix_valid;
  logic [DW-1:0]      col_in_0, col_in_1, col_in_2, col_in_3, col_in_4;
  logic [25*DW-1:0]   win_out;
  logic               win_valid;
  logic [CW-1:0]      win_row, win_col;
  logic               frame_done;

  conv_window_5x5 dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .pix_valid  (pix_valid),
    .col_in_0   (col_in_0),
    .col_in_1   (col_in_1),
    .col_in_2   (col_in_2),
    .col_in_3   (col_in_3),
    .col_in_4   (col_in_4),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int win_count   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame position derived from the pixel index in the frame.
  logic [DW-1:0] hist [5][5];
  bit            m_in_frame = 0;
  int            m_idx = 0, m_w = 32, m_row = 0, m_col = 0;
  logic [2:0]    m_mode = 3'b000;
  bit            m_valid = 0, m_done = 0;

  function automatic int side(input logic [2:0] m);
    case (m)
      3'd0: return 32;
      3'd1: return 28;
      3'd2: return 14;
      3'd3: return 10;
      3'd4: return 5;
      3'd5: return 28;
      3'd6: return 10;
      default: return 32;
    endcase
  endfunction

  function automatic bit legal_pos(input logic [2:0] m, input int r, input int c);
    if (m == 3'd5 || m == 3'd6) begin
`ifdef CONV_WINDOW_POOL_STRIDE2_EN
      return r >= 1 && c >= 1 && (r % 2) == 1 && (c % 2) == 1;
`else
      return r >= 1 && c >= 1;
`endif
    end
    return r >= 4 && c >= 4;
  endfunction

  function automatic logic [255:0] model_win();
    logic [255:0] v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        v[(r*5+c)*DW +: DW] = hist[r][c];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        hist[r][c] = '0;
    m_in_frame = 0; m_idx = 0; m_row = 0; m_col = 0;
    m_valid = 0; m_done = 0;
  endtask

  task automatic apply(input bit pv, input logic [4:0][DW-1:0] d);
    pix_valid = pv;
    col_in_0 = d[0]; col_in_1 = d[1]; col_in_2 = d[2]; col_in_3 = d[3]; col_in_4 = d[4];
    m_valid = 0;
    m_done  = 0;
    if (pv) begin
      if (!m_in_frame) begin
        m_mode = mode; m_w = side(mode); m_in_frame = 1; m_idx = 0;
      end
      m_row = m_idx / m_w;
      m_col = m_idx % m_w;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) hist[r][c] = hist[r][c+1];
        hist[r][4] = d[r];
      end
      m_valid = legal_pos(m_mode, m_row, m_col);
      m_done  = (m_idx == m_w * m_w - 1);
      if (m_done) m_in_frame = 0;
      m_idx++;
    end
    @(posedge clk);
    #1;
    if (win_valid) win_count++;
    check("win_valid", 256'(win_valid), 256'(m_valid));
    check("frame_done", 256'(frame_done), 256'(m_done));
    check("win_row", 256'(win_row), 256'(m_row));
    check("win_col", 256'(win_col), 256'(m_col));
    check("win_out", 256'(win_out), model_win());
  endtask

  task automatic do_reset_async();
    #2 rst = 1'b1;
    #1;
    check("rst_win_valid", 256'(win_valid), 256'(0));
    check("rst_frame_done", 256'(frame_done), 256'(0));
    check("rst_win_row", 256'(win_row), 256'(0));
    check("rst_win_col", 256'(win_col), 256'(0));
    check("rst_win_out", 256'(win_out), 256'(0));
    model_clear();
    pix_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // gap: 0 none, 1 alternate 1/0, 2 random gaps. pat: col_in_r = 10*r + col.
  task automatic run_frame(input string tag, input logic [2:0] m, input int gap,
                           input int chg_at, input logic [2:0] m2, input int rst_at,
                           input bit pat, input int exp_win);
    int seen0 = win_count;
    int npix = 0;
    int cyc = 0;
    int rst_pt = rst_at;
    bit pv;
    bit done = 0;
    logic [4:0][DW-1:0] d;
    mode = m;
    while (!done && cyc < 6000) begin
      case (gap)
        0:       pv = 1'b1;
        1:       pv = (cyc % 2) == 0;
        default: pv = $urandom_range(0, 3) != 0;
      endcase
      if (pv && npix == chg_at) mode = m2;
      if (pv && npix == rst_pt) begin
        do_reset_async();
        rst_pt = -1;
        npix   = 0;
        seen0  = win_count;
      end
      for (int r = 0; r < 5; r++)
        d[r] = pat ? DW'(10 * r + npix % 5) : DW'($urandom);
      apply(pv, d);
      if (pv) npix++;
      if (pv && m_done) done = 1;
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 256'(0), 256'(1));
    check({tag, "_windows"}, 256'(win_count - seen0), 256'(exp_win));
  endtask

  initial begin
    rst = 1'b1;
    mode = 3'b000;
    pix_valid = 1'b0;
    col_in_0 = '0; col_in_1 = '0; col_in_2 = '0; col_in_3 = '0; col_in_4 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_win_valid", 256'(win_valid), 256'(0));
    check("reset_frame_done", 256'(frame_done), 256'(0));
    check("reset_win_row", 256'(win_row), 256'(0));
    check("reset_win_col", 256'(win_col), 256'(0));
    check("reset_win_out", 256'(win_out), 256'(0));
    #3 rst = 1'b0;

    run_frame("m4_pattern", 3'd4, 0, -1, 3'd0, -1, 1'b1, 1);
    run_frame("m0_full",    3'd0, 0, -1, 3'd0, -1, 1'b0, 784);
    run_frame("m1_toggle",  3'd1, 1, -1, 3'd0, -1, 1'b0, 576);
`ifdef CONV_WINDOW_POOL_STRIDE2_EN
    run_frame("m5_pool",    3'd5, 2, -1, 3'd0, -1, 1'b0, 196);
    run_frame("m6_pool",    3'd6, 0, -1, 3'd0, -1, 1'b0, 25);
`else
    run_frame("m5_pool",    3'd5, 2, -1, 3'd0, -1, 1'b0, 729);
    run_frame("m6_pool",    3'd6, 0, -1, 3'd0, -1, 1'b0, 81);
`endif
    run_frame("m0_chg",     3'd0, 0, 100, 3'd3, -1, 1'b0, 784);
    run_frame("m3_next",    3'd3, 0, -1, 3'd3, -1, 1'b0, 36);
    run_frame("m0_rst",     3'd0, 0, -1, 3'd0, 500, 1'b0, 784);
    run_frame("m2_gaps",    3'd2, 2, -1, 3'd0, -1, 1'b0, 100);
    run_frame("m7_gaps",    3'd7, 2, -1, 3'd0, -1, 1'b0, 784);
    run_frame("m4_rand",    3'd4, 2, -1, 3'd0, -1, 1'b0, 1);

    pix_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
